cmd_frame_decoder: RTL

//  Parses the byte stream from the host serial receiver into register writes for the

---
 rtl/cmd_frame_if.sv | 23 ++
 rtl/cmd_frame_decoder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cmd_frame_if.sv
// Byte-stream input and register-bank output bundle for cmd_frame_decoder.
// The master drives the received bytes, and the slave (the decoder) drives the writes.
interface cmd_frame_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] dout;
  logic       rg1;
  logic       rg2;
  logic       rg3;
  logic       frame_err;
  logic [7:0] err_cnt;

  modport master (
    output rx_data, rx_valid, rx_err,
    input  dout, rg1, rg2, rg3, frame_err, err_cnt
  );

  modport slave (
    input  rx_data, rx_valid, rx_err,
    output dout, rg1, rg2, rg3, frame_err, err_cnt
  );
endinterface

// File: rtl/cmd_frame_decoder.sv
// Decodes HEADER/ADDR/DATA/CSUM byte frames into single-cycle register write strobes.
// Bad, corrupted or stalled frames are dropped, and a saturating counter records them.
module cmd_frame_decoder #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         CNT_W       = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  cmd_frame_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_CSUM} state_t;

  // Counter value on the last gap cycle allowed before the frame is abandoned.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 2);

  function automatic logic [7:0] csum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'h01;
  endfunction

  state_t           r_state;
  logic [7:0]       r_addr;
  logic [7:0]       r_data;
  logic [CNT_W-1:0] r_tcnt;
  logic [7:0]       r_dout;
  logic             r_rg1;
  logic             r_rg2;
  logic             r_rg3;
  logic             r_ferr;
  logic [7:0]       r_err_cnt;

  logic w_abort;
  logic w_write;
  logic w_addr_ok;

  assign w_addr_ok = (r_addr == 8'h01) || (r_addr == 8'h02) || (r_addr == 8'h03);

  // Decide whether this edge completes a frame or abandons it.
  always_comb begin
    w_abort = 1'b0;
    w_write = 1'b0;
    if (r_state == S_IDLE) begin
      w_abort = 1'b0;
    end else if (bus.rx_err) begin
      w_abort = 1'b1;
    end else if (bus.rx_valid) begin
      if (r_state == S_CSUM) begin
        if (w_addr_ok && (csum8(r_addr, r_data) == bus.rx_data)) begin
          w_write = 1'b1;
        end else begin
          w_abort = 1'b1;
        end
      end else begin
        w_write = 1'b0;
      end
    end else if (r_tcnt == TO_LAST) begin
      w_abort = 1'b1;
    end else begin
      w_abort = 1'b0;
    end
  end

  // Frame FSM, timeout counter and registered bank outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_addr    <= 8'h00;
      r_data    <= 8'h00;
      r_tcnt    <= '0;
      r_dout    <= 8'h00;
      r_rg1     <= 1'b0;
      r_rg2     <= 1'b0;
      r_rg3     <= 1'b0;
      r_ferr    <= 1'b0;
      r_err_cnt <= 8'h00;
    end else begin
      r_rg1  <= w_write && (r_addr == 8'h01);
      r_rg2  <= w_write && (r_addr == 8'h02);
      r_rg3  <= w_write && (r_addr == 8'h03);
      r_ferr <= w_abort;
      if (w_write) begin
        r_dout <= r_data;
      end
      if (w_abort) begin
        r_err_cnt <= sat_inc8(r_err_cnt);
        r_state   <= S_IDLE;
        r_tcnt    <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_tcnt <= '0;
            if (bus.rx_valid && (bus.rx_data == HEADER)) begin
              r_state <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (bus.rx_valid) begin
              r_addr  <= bus.rx_data;
              r_tcnt  <= '0;
              r_state <= S_DATA;
            end else begin
              r_tcnt <= r_tcnt + CNT_W'(1);
            end
          end
          S_DATA: begin
            if (bus.rx_valid) begin
              r_data  <= bus.rx_data;
              r_tcnt  <= '0;
              r_state <= S_CSUM;
            end else begin
              r_tcnt <= r_tcnt + CNT_W'(1);
            end
          end
          S_CSUM: begin
            if (bus.rx_valid) begin
              r_tcnt  <= '0;
              r_state <= S_IDLE;
            end else begin
              r_tcnt <= r_tcnt + CNT_W'(1);
            end
          end
          default: begin
            r_tcnt  <= '0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.dout      = r_dout;
  assign bus.rg1       = r_rg1;
  assign bus.rg2       = r_rg2;
  assign bus.rg3       = r_rg3;
  assign bus.frame_err = r_ferr;
  assign bus.err_cnt   = r_err_cnt;

endmodule
